// File: rtl/ber_accum.sv
// ber_accum: windowed bit/error accumulator with hold-until-ack result (optional lifetime totals under BER_ACCUM_TOTAL_EN)
module ber_accum #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               error_flag,
  input  logic               start,
  input  logic [CNT_W-1:0]   win_len,
  input  logic               ack,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   bit_count,
  output logic [CNT_W-1:0]   err_count,
`ifdef BER_ACCUM_TOTAL_EN
  output logic [CNT_W+15:0]  err_total,
  output logic [CNT_W+15:0]  bit_total,
`endif
  output logic               err_sat
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, bit_q, bit_d, err_q, err_d;
  logic sat_q, sat_d;
  logic bit_inc, err_inc, err_max;
  assign bit_inc = (state_q == RUN) && enable;
  assign err_inc = bit_inc && error_flag;
  assign err_max = &err_q;
  // state and window registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      bit_q   <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end
  // next state: zero-length window skips straight to HOLD; ack wins over start in HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ((win_len == '0) ? HOLD : RUN) : IDLE;
      RUN:     state_d = (bit_inc && (bit_q + CNT_W'(1) == len_q)) ? HOLD : RUN;
      HOLD:    state_d = ack ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // window counters: cleared on accepted start, advanced on strobes in RUN, error count saturates
  always_comb begin
    len_d = len_q;
    bit_d = bit_q;
    err_d = err_q;
    sat_d = sat_q;
    if (state_q == IDLE && start) begin
      len_d = win_len;
      bit_d = '0;
      err_d = '0;
      sat_d = 1'b0;
    end else if (bit_inc) begin
      bit_d = bit_q + CNT_W'(1);
      err_d = (err_inc && !err_max) ? err_q + CNT_W'(1) : err_q;
      sat_d = sat_q | (err_inc && err_max);
    end
  end
  // outputs come straight from registers
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == HOLD);
    bit_count = bit_q;
    err_count = err_q;
    err_sat   = sat_q;
  end
`ifdef BER_ACCUM_TOTAL_EN
  logic [CNT_W+15:0] btot_q, etot_q;
  // lifetime totals, cleared only by reset, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      btot_q <= '0;
      etot_q <= '0;
    end else begin
      btot_q <= (bit_inc && !(&btot_q)) ? btot_q + (CNT_W+16)'(1) : btot_q;
      etot_q <= (err_inc && !(&etot_q)) ? etot_q + (CNT_W+16)'(1) : etot_q;
    end
  end
  assign bit_total = btot_q;
  assign err_total = etot_q;
`endif
endmodule

// File: doc/ber_accum.md
# ber_accum

Windowed bit/error accumulator that sits directly downstream of the `ber` checker in the QPSK link. It consumes the `ber` symbol strobe and `error_flag`, and counts compared bits and errored bits over a programmable window. It then holds the result for a host or test sequencer until acknowledged. It turns the per-bit error flag into a measurable BER figure (err_count / bit_count).

## Interface
Parameters:
- `CNT_W`, 32, width of bit and error counters and of the window length.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  bit strobe; same strobe that drives `ber` (one cycle high per compared bit).
- `error_flag`  in  1  mismatch flag from `ber`; sampled only when `enable`=1.
- `start`  in  1  single-cycle request to open a new window.
- `win_len`  in  CNT_W  number of strobed bits per window; sampled on accepted `start`.
- `ack`  in  1  host acknowledge of a held result.
- `busy`  out  1  high while a window is counting.
- `done`  out  1  high while a finished result is held.
- `bit_count`  out  CNT_W  bits counted in the current or last window.
- `err_count`  out  CNT_W  errors counted in the current or last window.
- `err_sat`  out  1  `err_count` saturated during the window.

## Operation
- States: IDLE, RUN, HOLD. Reset state IDLE.
- IDLE:
  - `start`=1 latches `win_len`, clears `bit_count`, `err_count` and `err_sat`.
  - Goes to RUN, or directly to HOLD if `win_len`=0.
  - Counts retain the last window's values until a `start` is accepted.
- RUN: on each cycle with `enable`=1:
  - `bit_count` += 1.
  - If `error_flag`=1, `err_count` += 1.
  - `err_count` saturates at 2^CNT_W−1 and sets `err_sat`; it does not wrap.
  - When the increment makes `bit_count` equal the latched length, go to HOLD.
- HOLD:
  - Counts are frozen.
  - `ack`=1 returns to IDLE.
- `start` is ignored in RUN and HOLD.
- `ack` is ignored outside HOLD.
- `ack` and `start` together in HOLD: `ack` is taken and `start` is dropped; the host re-issues `start` in IDLE.
- `enable` and `error_flag` are ignored in IDLE and HOLD.
- `error_flag` with `enable`=0 is never counted.
- `bit_count` cannot exceed the latched length. The latched length is unaffected by `win_len` changes after `start`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `bit_count`=0, `err_count`=0, `err_sat`=0.
- `start` accepted at edge N:
  - `busy`=1 from N+1.
  - An `enable` in the same cycle as `start` is not counted.
  - The first countable strobe is sampled at edge N+1.
- Final strobe sampled at edge M: from M+1, `busy`=0, `done`=1 and final counts are visible.
- `win_len`=0: `done`=1 at N+1 with both counts 0; `busy` stays 0.
- `ack` sampled at edge K: `done`=0 from K+1. A new `start` is accepted at K+1 at the earliest.
- `rst`=1 at any edge, including mid-window: state IDLE and all outputs at reset values from the next cycle.
- Throughput: one counted bit per cycle (`enable` held high) is supported.

## Configuration
- Macro `BER_ACCUM_TOTAL_EN`.
- Defined:
  - Adds output `err_total` (out, CNT_W+16) and output `bit_total` (out, CNT_W+16).
  - They accumulate every counted error and bit across all windows.
  - They are cleared only by `rst`, not by `start`.
  - They saturate at all-ones.
  - They update in the same cycle as `err_count` and `bit_count`.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Reset: assert `rst` for 3 cycles mid-RUN (`win_len`=100, after 40 strobes) -> next cycle `busy`=0, `done`=0, counts 0; a fresh `start` then counts from 0.
- Error-free window: `start` with `win_len`=1000, `enable` 1-in-4 as in the link, `error_flag`=0 -> `done` 1 cycle after the 1000th strobe, `bit_count`=1000, `err_count`=0; `done` held until `ack`, cleared the cycle after.
- Known errors: `win_len`=64, `enable` every cycle, `error_flag`=1 on strobes 0, 10 and 63, plus an `error_flag` pulse with `enable`=0 -> `err_count`=3, `bit_count`=64.
- Boundaries:
  - `win_len`=0 -> `done` next cycle, counts 0.
  - `win_len`=1 with `enable` in the start cycle -> that strobe is not counted; `done` after the next strobe.
- Saturation with CNT_W=4: `win_len`=15, all strobes errored -> `err_count`=15 and `err_sat`=0. Then a window of 15 bits with `error_flag` held 1 and `start` pulsed during RUN -> the `start` is ignored and counts are unaffected.
- With `BER_ACCUM_TOTAL_EN`: two windows of 50 bits with 5 and 7 errors -> `err_total`=12 and `bit_total`=100 after the second `done`; both are cleared only by `rst`.
